// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter.
//   state_t  : arbiter ownership state (IDLE, OWN_CPU, OWN_DBG)
//   REQ_CPU  : requester id / grant-vector bit of the CPU load/store path
//   REQ_DBG  : requester id / grant-vector bit of the debug/DMA requester
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DBG = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_rr_core.sv
// ---------------------------------------------------------------------------
// dmem_arb_rr_core
// Round-robin arbitration core with a CPU lock limiter.
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   i_cpuReq    in   CPU request
//   i_cpuLock   in   CPU asks to keep ownership (read-modify-write)
//   i_dbgReq    in   debug/DMA request
//   o_gnt[1:0]  out  one-hot grant, bit REQ_CPU / REQ_DBG (combinational)
// Parameter:
//   MAX_LOCK    locked CPU cycles tolerated before a waiting DBG request wins
// ---------------------------------------------------------------------------
module dmem_arb_rr_core
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_cpuReq,
  input  logic       i_cpuLock,
  input  logic       i_dbgReq,
  output logic [1:0] o_gnt
);

  localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastWinner;
  logic             w_nextLast;
  logic [CNT_W-1:0] r_lockCnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [1:0]       w_gnt;
  logic             w_lockActive;

  // Grant decision. A lock only counts once the CPU already owns the port;
  // the cycle that wins ownership is the first of the locked burst, so with
  // MAX_LOCK = 4 the CPU holds for five cycles before a waiting DBG gets in.
  // The counter saturates when nobody is waiting to be forced through.
  always_comb begin
    w_gnt        = 2'b00;
    w_nextCnt    = r_lockCnt;
    w_lockActive = (r_state == OWN_CPU) && i_cpuReq && i_cpuLock;

    if (w_lockActive) begin
      if (i_dbgReq && (r_lockCnt == MAX_CNT)) begin
        w_gnt[REQ_DBG] = 1'b1;
        w_nextCnt      = '0;
      end else begin
        w_gnt[REQ_CPU] = 1'b1;
        w_nextCnt      = (r_lockCnt == MAX_CNT) ? r_lockCnt : r_lockCnt + 1'b1;
      end
    end else begin
      w_nextCnt = '0;
      if (i_cpuReq && i_dbgReq) begin
        if (r_lastWinner == REQ_DBG) w_gnt[REQ_CPU] = 1'b1;
        else                         w_gnt[REQ_DBG] = 1'b1;
      end else if (i_cpuReq) begin
        w_gnt[REQ_CPU] = 1'b1;
      end else if (i_dbgReq) begin
        w_gnt[REQ_DBG] = 1'b1;
      end
    end
  end

  // Ownership follows the granted requester; an idle cycle returns to IDLE
  // but keeps the last winner so the round-robin order survives gaps.
  always_comb begin
    w_nextState = IDLE;
    w_nextLast  = r_lastWinner;
    if (w_gnt[REQ_CPU]) begin
      w_nextState = OWN_CPU;
      w_nextLast  = REQ_CPU;
    end else if (w_gnt[REQ_DBG]) begin
      w_nextState = OWN_DBG;
      w_nextLast  = REQ_DBG;
    end
  end

  // Last winner resets to DBG so the CPU takes the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_lastWinner <= REQ_DBG;
      r_lockCnt    <= '0;
    end else begin
      r_state      <= w_nextState;
      r_lastWinner <= w_nextLast;
      r_lockCnt    <= w_nextCnt;
    end
  end

  // Grants are forced low while reset is asserted so an in-flight access
  // is dropped immediately rather than at the next edge.
  assign o_gnt = reset ? w_gnt : 2'b00;

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one single-port data memory between the CPU load/store path and a
// debug/DMA requester: one access per cycle, round-robin with a bounded CPU
// lock, read data returned one cycle after the grant.
// Ports:
//   clock, reset                        clock / asynchronous active-low reset
//   cpu_req/we/lock/addr/wdata    in    CPU request fields
//   cpu_gnt/rvalid/rdata          out   CPU grant and read return
//   dbg_req/we/addr/wdata         in    debug request fields
//   dbg_gnt/rvalid/rdata          out   debug grant and read return
//   mem_we/addr/wdata             out   memory command (granted requester)
//   mem_rdata                     in    memory read data (combinational)
//   cpu_grant_cnt, dbg_grant_cnt,
//   conflict_cnt                  out   only with DMEM_ARB_PERF_EN defined
// Build option: DMEM_ARB_PERF_EN adds free-running grant/conflict counters.
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       cpu_grant_cnt,
  output logic [31:0]       dbg_grant_cnt,
  output logic [31:0]       conflict_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        w_gnt;
  logic              w_cpuGnt;
  logic              w_dbgGnt;
  logic              w_cpuRead;
  logic              w_dbgRead;
  logic              r_cpuRvalid;
  logic              r_dbgRvalid;
  logic [DATA_W-1:0] r_cpuRdata;
  logic [DATA_W-1:0] r_dbgRdata;

  dmem_arb_rr_core #(
    .MAX_LOCK (MAX_LOCK)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .i_cpuReq  (cpu_req),
    .i_cpuLock (cpu_lock),
    .i_dbgReq  (dbg_req),
    .o_gnt     (w_gnt)
  );

  assign w_cpuGnt  = w_gnt[REQ_CPU];
  assign w_dbgGnt  = w_gnt[REQ_DBG];
  assign w_cpuRead = w_cpuGnt & ~cpu_we;
  assign w_dbgRead = w_dbgGnt & ~dbg_we;

  assign cpu_gnt = w_cpuGnt;
  assign dbg_gnt = w_dbgGnt;

  // Memory command mux; with no grant the bus is parked at zero so nothing
  // stale reaches the memory and the reset state is all-zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpuGnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbgGnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read return: capture at the grant edge, rvalid for exactly one cycle.
  // Each requester keeps its last read data until its next granted read,
  // so a new capture and the previous return overlap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cpuRvalid <= 1'b0;
      r_dbgRvalid <= 1'b0;
      r_cpuRdata  <= '0;
      r_dbgRdata  <= '0;
    end else begin
      r_cpuRvalid <= w_cpuRead;
      r_dbgRvalid <= w_dbgRead;
      if (w_cpuRead) r_cpuRdata <= mem_rdata;
      if (w_dbgRead) r_dbgRdata <= mem_rdata;
    end
  end

  assign cpu_rvalid = r_cpuRvalid;
  assign dbg_rvalid = r_dbgRvalid;
  assign cpu_rdata  = r_cpuRdata;
  assign dbg_rdata  = r_dbgRdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_cpuGrantCnt;
  logic [31:0] r_dbgGrantCnt;
  logic [31:0] r_conflictCnt;

  // Performance counters wrap naturally at 2^32; a conflict is any cycle
  // where both requesters ask, whoever ends up winning.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cpuGrantCnt <= '0;
      r_dbgGrantCnt <= '0;
      r_conflictCnt <= '0;
    end else begin
      r_cpuGrantCnt <= r_cpuGrantCnt + 32'(w_cpuGnt);
      r_dbgGrantCnt <= r_dbgGrantCnt + 32'(w_dbgGnt);
      r_conflictCnt <= r_conflictCnt + 32'(cpu_req & dbg_req);
    end
  end

  assign cpu_grant_cnt = r_cpuGrantCnt;
  assign dbg_grant_cnt = r_dbgGrantCnt;
  assign conflict_cnt  = r_conflictCnt;
`endif

endmodule
